// File: rtl/systolic_feeder_if.sv
// Handshake and skewed-lane bus between a job source and the systolic feeder.
interface systolic_feeder_if #(
   parameter int unsigned SIZE   = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned K_MAX  = 16
);
   localparam int unsigned KW = $clog2(K_MAX + 1);
   localparam int unsigned LW = SIZE * DATA_W;

   logic          start_i;
   logic [KW-1:0] k_len_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [LW-1:0] a_col_i;
   logic [LW-1:0] b_row_i;
   logic [LW-1:0] a_o;
   logic [LW-1:0] b_o;
   logic          busy_o;
   logic          done_o;
   logic          timeout_o;
   logic [31:0]   cycle_cnt_o;

   modport master (
      output start_i, k_len_i, in_valid_i, a_col_i, b_row_i,
      input  in_ready_o, a_o, b_o, busy_o, done_o, timeout_o, cycle_cnt_o
   );

   modport slave (
      input  start_i, k_len_i, in_valid_i, a_col_i, b_row_i,
      output in_ready_o, a_o, b_o, busy_o, done_o, timeout_o, cycle_cnt_o
   );
endinterface

// File: rtl/systolic_feeder.sv
// Feeds A columns / B rows into a systolic array with per-lane diagonal skew,
// flushes the array with zeros, and reports completion, cycle count and watchdog.
module systolic_feeder #(
   parameter int unsigned SIZE    = 4,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned K_MAX   = 16,
   parameter int unsigned TIMEOUT = 1024
) (
   input logic             clk_i,
   input logic             rst_ni,
   systolic_feeder_if.slave bus
);
   localparam int unsigned KW = $clog2(K_MAX + 1);
   localparam int unsigned DW = (SIZE > 1) ? $clog2(2 * SIZE) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * SIZE - 2);
   localparam logic [31:0]   WD_LAST    = 32'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t        state;
   logic [KW-1:0] k_len_q;
   logic [KW-1:0] k_cnt;
   logic [DW-1:0] drain_cnt;
   logic          hs;
   logic          wd_abort;

   assign hs       = (state == FEED) && bus.in_valid_i && bus.in_ready_o;
   assign wd_abort = bus.busy_o && (bus.cycle_cnt_o == WD_LAST);

   // Job sequencing; the watchdog abort overrides any state transition.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state           <= IDLE;
         k_len_q         <= '0;
         k_cnt           <= '0;
         drain_cnt       <= '0;
         bus.in_ready_o  <= 1'b0;
         bus.busy_o      <= 1'b0;
         bus.done_o      <= 1'b0;
         bus.timeout_o   <= 1'b0;
         bus.cycle_cnt_o <= '0;
      end else begin
         bus.done_o <= 1'b0;
         if (bus.busy_o && (bus.cycle_cnt_o != '1))
            bus.cycle_cnt_o <= bus.cycle_cnt_o + 32'd1;

         if (wd_abort) begin
            state          <= IDLE;
            bus.in_ready_o <= 1'b0;
            bus.busy_o     <= 1'b0;
            bus.timeout_o  <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start_i) begin
                     bus.timeout_o   <= 1'b0;
                     // The start cycle itself counts as the first elapsed cycle.
                     bus.cycle_cnt_o <= 32'd1;
                     k_len_q         <= bus.k_len_i;
                     k_cnt           <= '0;
                     if (bus.k_len_i == '0) begin
                        state      <= DONE;
                        bus.done_o <= 1'b1;
                     end else begin
                        state          <= FEED;
                        bus.in_ready_o <= 1'b1;
                        bus.busy_o     <= 1'b1;
                     end
                  end
               end
               FEED: begin
                  if (hs) begin
                     k_cnt <= k_cnt + KW'(1);
                     if ((k_cnt + KW'(1)) == k_len_q) begin
                        state          <= DRAIN;
                        bus.in_ready_o <= 1'b0;
                        drain_cnt      <= '0;
                     end
                  end
               end
               DRAIN: begin
                  if (drain_cnt == DRAIN_LAST) begin
                     state      <= DONE;
                     bus.done_o <= 1'b1;
                     bus.busy_o <= 1'b0;
                  end else begin
                     drain_cnt <= drain_cnt + DW'(1);
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Lane i is an (i+1)-deep shift chain; non-handshake cycles push aligned zeros.
   for (genvar i = 0; i < SIZE; i++) begin : g_lane
      logic [DATA_W-1:0] a_sr [i+1];
      logic [DATA_W-1:0] b_sr [i+1];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int j = 0; j <= i; j++) begin
               a_sr[j] <= '0;
               b_sr[j] <= '0;
            end
         end else if (wd_abort) begin
            for (int j = 0; j <= i; j++) begin
               a_sr[j] <= '0;
               b_sr[j] <= '0;
            end
         end else begin
            a_sr[0] <= hs ? bus.a_col_i[i*DATA_W +: DATA_W] : '0;
            b_sr[0] <= hs ? bus.b_row_i[i*DATA_W +: DATA_W] : '0;
            for (int j = 1; j <= i; j++) begin
               a_sr[j] <= a_sr[j-1];
               b_sr[j] <= b_sr[j-1];
            end
         end
      end

      assign bus.a_o[i*DATA_W +: DATA_W] = a_sr[i];
      assign bus.b_o[i*DATA_W +: DATA_W] = b_sr[i];
   end
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: job table plus scoreboard of skewed lanes and a
// behavioural output-stationary array checking the final product.
module tb_systolic_feeder;
   localparam int unsigned S  = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned KM = 16;
   localparam int unsigned TO = 20;

   logic clk;
   logic rst_n;

   systolic_feeder_if #(.SIZE(S), .DATA_W(DW), .K_MAX(KM)) sif ();

   systolic_feeder #(.SIZE(S), .DATA_W(DW), .K_MAX(KM), .TIMEOUT(TO)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned k;
      int unsigned pat;       // 0 valid held, 1 every other cycle, 2 first two cycles idle
      bit          mid_start;
      int unsigned a_base;
      int unsigned b_base;
      int unsigned b_lane;
      int unsigned exp_cnt;
   } job_t;

   typedef struct {
      int unsigned due;
      int unsigned lane;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } sb_t;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;
   bit          chk_en = 1'b0;
   sb_t         sb_q[$];
   job_t        jobs[6];

   logic [DW-1:0] ah [S][S];
   logic [DW-1:0] bv [S][S];
   int unsigned   acc[S][S];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, got, exp);
      end
   endtask

   task automatic check_lanes();
      logic [S*DW-1:0] ea;
      logic [S*DW-1:0] eb;
      ea = '0;
      eb = '0;
      for (int q = sb_q.size() - 1; q >= 0; q--) begin
         if (sb_q[q].due == cyc) begin
            ea[sb_q[q].lane*DW +: DW] = sb_q[q].a;
            eb[sb_q[q].lane*DW +: DW] = sb_q[q].b;
            sb_q.delete(q);
         end
      end
      chk("a_lanes", 64'(sif.a_o), 64'(ea));
      chk("b_lanes", 64'(sif.b_o), 64'(eb));
   endtask

   task automatic model_clear();
      for (int i = 0; i < S; i++)
         for (int j = 0; j < S; j++) begin
            ah[i][j]  = '0;
            bv[i][j]  = '0;
            acc[i][j] = 0;
         end
   endtask

   task automatic model_step();
      logic [DW-1:0] na [S][S];
      logic [DW-1:0] nb [S][S];
      logic [DW-1:0] ain, bin;
      for (int i = 0; i < S; i++)
         for (int j = 0; j < S; j++) begin
            ain = (j == 0) ? sif.a_o[i*DW +: DW] : ah[i][j-1];
            bin = (i == 0) ? sif.b_o[j*DW +: DW] : bv[i-1][j];
            acc[i][j] = acc[i][j] + 32'(ain) * 32'(bin);
            na[i][j] = ain;
            nb[i][j] = bin;
         end
      ah = na;
      bv = nb;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (chk_en) check_lanes();
      model_step();
   endtask

   task automatic drive_idle();
      sif.start_i    = 1'b0;
      sif.in_valid_i = 1'b0;
      sif.a_col_i    = '0;
      sif.b_row_i    = '0;
   endtask

   task automatic drive_step(input job_t jb, input int unsigned step,
                             inout logic [DW-1:0] am[S][KM], inout logic [DW-1:0] bm[KM][S]);
      for (int i = 0; i < S; i++) begin
         am[i][step] = DW'(jb.a_base + 10 * step + i);
         bm[step][i] = DW'(jb.b_base + step + jb.b_lane * i);
         sif.a_col_i[i*DW +: DW] = am[i][step];
         sif.b_row_i[i*DW +: DW] = bm[step][i];
         sb_q.push_back('{due: cyc + i + 1, lane: i, a: am[i][step], b: bm[step][i]});
      end
      sif.in_valid_i = 1'b1;
   endtask

   task automatic run_job(input job_t jb);
      logic [DW-1:0] am [S][KM];
      logic [DW-1:0] bm [KM][S];
      int unsigned s, hlast, step, guard, rel, cexp;
      bit vld, got;
      s = cyc;
      hlast = cyc;
      model_clear();
      sif.start_i = 1'b1;
      sif.k_len_i = 5'(jb.k);
      tick();
      sif.start_i = 1'b0;
      chk("start_busy", 64'(sif.busy_o), 64'd1);
      chk("start_timeout_clr", 64'(sif.timeout_o), 64'd0);
      step  = 0;
      guard = 0;
      while (step < jb.k && guard < 64) begin
         rel = cyc - s;
         case (jb.pat)
            1:       vld = ((rel - 1) % 2) == 0;
            2:       vld = rel >= 3;
            default: vld = 1'b1;
         endcase
         if (jb.mid_start && rel == 2) begin
            sif.start_i = 1'b1;
            sif.k_len_i = 5'd1;
         end
         if (vld) begin
            drive_step(jb, step, am, bm);
            chk("ready_feed", 64'(sif.in_ready_o), 64'd1);
            hlast = cyc;
            step++;
         end else begin
            sif.in_valid_i = 1'b0;
            sif.a_col_i    = $urandom;
            sif.b_row_i    = $urandom;
         end
         tick();
         sif.start_i = 1'b0;
         guard++;
      end
      chk("ready_drop", 64'(sif.in_ready_o), 64'd0);
      chk("drain_busy", 64'(sif.busy_o), 64'd1);
      // Junk with valid high outside FEED must never reach the lanes.
      sif.in_valid_i = 1'b1;
      sif.a_col_i    = $urandom;
      sif.b_row_i    = $urandom;
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         if (sif.done_o) got = 1'b1;
         else tick();
      end
      chk("done_seen", 64'(got), 64'd1);
      chk("done_latency", 64'(cyc - hlast), 64'(2 * S));
      chk("cycle_cnt", 64'(sif.cycle_cnt_o), 64'(jb.exp_cnt));
      chk("done_busy", 64'(sif.busy_o), 64'd0);
      for (int i = 0; i < S; i++)
         for (int j = 0; j < S; j++) begin
            cexp = 0;
            for (int k = 0; k < int'(jb.k); k++)
               cexp = cexp + 32'(am[i][k]) * 32'(bm[k][j]);
            chk("matrix", 64'(acc[i][j]), 64'(cexp));
         end
      drive_idle();
      tick();
      chk("done_pulse", 64'(sif.done_o), 64'd0);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got running want finished");
      $fatal(1);
   end

   initial begin
      int unsigned s;
      bit got, saw_done, saw_busy;
      jobs[0] = '{k: 3, pat: 0, mid_start: 0, a_base: 0,  b_base: 100, b_lane: 0, exp_cnt: 11};
      jobs[1] = '{k: 3, pat: 1, mid_start: 0, a_base: 0,  b_base: 100, b_lane: 0, exp_cnt: 13};
      jobs[2] = '{k: 3, pat: 0, mid_start: 1, a_base: 5,  b_base: 7,   b_lane: 2, exp_cnt: 11};
      jobs[3] = '{k: 1, pat: 0, mid_start: 0, a_base: 20, b_base: 3,   b_lane: 1, exp_cnt: 9};
      jobs[4] = '{k: 8, pat: 0, mid_start: 0, a_base: 1,  b_base: 1,   b_lane: 3, exp_cnt: 16};
      jobs[5] = '{k: 2, pat: 2, mid_start: 0, a_base: 50, b_base: 9,   b_lane: 5, exp_cnt: 12};

      rst_n = 1'b0;
      sif.k_len_i = '0;
      drive_idle();
      model_clear();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_a", 64'(sif.a_o), 64'd0);
      chk("rst_b", 64'(sif.b_o), 64'd0);
      chk("rst_ready", 64'(sif.in_ready_o), 64'd0);
      chk("rst_busy", 64'(sif.busy_o), 64'd0);
      chk("rst_done", 64'(sif.done_o), 64'd0);
      chk("rst_timeout", 64'(sif.timeout_o), 64'd0);
      chk("rst_cnt", 64'(sif.cycle_cnt_o), 64'd0);
      chk_en = 1'b1;

      for (int t = 0; t < 6; t++) run_job(jobs[t]);

      // k_len = 0: immediate done, never busy.
      sif.start_i = 1'b1;
      sif.k_len_i = '0;
      tick();
      sif.start_i = 1'b0;
      chk("k0_done", 64'(sif.done_o), 64'd1);
      chk("k0_busy", 64'(sif.busy_o), 64'd0);
      tick();
      chk("k0_done_end", 64'(sif.done_o), 64'd0);
      chk("k0_busy_end", 64'(sif.busy_o), 64'd0);

      // Watchdog: valid never offered.
      s = cyc;
      sif.start_i = 1'b1;
      sif.k_len_i = 5'd5;
      tick();
      sif.start_i = 1'b0;
      got = 1'b0;
      saw_done = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         if (sif.timeout_o) got = 1'b1;
         else begin
            saw_done |= sif.done_o;
            tick();
         end
      end
      chk("wd_seen", 64'(got), 64'd1);
      chk("wd_cycle", 64'(cyc - s), 64'(TO));
      chk("wd_no_done", 64'(saw_done | sif.done_o), 64'd0);
      chk("wd_busy", 64'(sif.busy_o), 64'd0);
      chk("wd_ready", 64'(sif.in_ready_o), 64'd0);
      tick();
      chk("wd_sticky", 64'(sif.timeout_o), 64'd1);
      chk("wd_idle_busy", 64'(sif.busy_o), 64'd0);
      run_job(jobs[3]);

      // Asynchronous reset during DRAIN, then a clean job.
      model_clear();
      sif.start_i = 1'b1;
      sif.k_len_i = 5'd2;
      tick();
      sif.start_i = 1'b0;
      for (int st = 0; st < 2; st++) begin
         for (int i = 0; i < S; i++) begin
            sif.a_col_i[i*DW +: DW] = DW'(30 + 10 * st + i);
            sif.b_row_i[i*DW +: DW] = DW'(60 + st + i);
            sb_q.push_back('{due: cyc + i + 1, lane: i,
                             a: DW'(30 + 10 * st + i), b: DW'(60 + st + i)});
         end
         sif.in_valid_i = 1'b1;
         tick();
      end
      drive_idle();
      tick();
      chk("drain_state_busy", 64'(sif.busy_o), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_a", 64'(sif.a_o), 64'd0);
      chk("arst_b", 64'(sif.b_o), 64'd0);
      chk("arst_busy", 64'(sif.busy_o), 64'd0);
      chk("arst_ready", 64'(sif.in_ready_o), 64'd0);
      chk("arst_cnt", 64'(sif.cycle_cnt_o), 64'd0);
      chk_en = 1'b0;
      sb_q.delete();
      tick();
      #2;
      rst_n = 1'b1;
      tick();
      chk_en = 1'b1;
      saw_busy = sif.busy_o;
      chk("post_rst_idle", 64'(saw_busy), 64'd0);
      run_job(jobs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
